// File: rtl/fast_segment_test.sv
// FAST-16 segment test: two-stage pipeline from ring pixels to corner flag, polarity and count.
// Optional macro FAST_SCORE_EN adds the max(S_b, S_d) corner score; without it corner_score is tied to 0.
module fast_segment_test #(
  parameter int DATA_WIDTH = 8,
  parameter int ARC_LEN    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    circle_valid,
  input  logic [DATA_WIDTH-1:0]   center_pixel,
  input  logic [DATA_WIDTH-1:0]   circle_pixel [0:15],
  input  logic [DATA_WIDTH-1:0]   threshold,
  input  logic                    frame_start,
  output logic                    corner_valid,
  output logic                    is_corner,
  output logic                    corner_dark,
  output logic [DATA_WIDTH+3:0]   corner_score,
  output logic [15:0]             corner_count
);

  localparam int EW = DATA_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 4;

  generate
    if (ARC_LEN < 9 || ARC_LEN > 12) begin : g_bad_arc_len
      $error("fast_segment_test: ARC_LEN must lie in 9..12");
    end
  endgenerate

  // True when the circular mask contains ARC_LEN or more consecutive ones.
  function automatic logic arc_pass(input logic [15:0] mask);
    logic [31:0] ring;
    logic        hit;
    logic        run;
    ring = {mask, mask};
    hit  = 1'b0;
    for (int s = 0; s < 16; s++) begin
      run = 1'b1;
      for (int k = 0; k < ARC_LEN; k++) begin
        run = run & ring[s+k];
      end
      hit = hit | run;
    end
    return hit;
  endfunction

  logic          v1_q, v1_d;
  logic [15:0]   bright_mask_q, bright_mask_d;
  logic [15:0]   dark_mask_q, dark_mask_d;
  logic          corner_valid_q, corner_valid_d;
  logic          is_corner_q, is_corner_d;
  logic          corner_dark_q, corner_dark_d;
  logic [15:0]   corner_count_q, corner_count_d;
  logic [EW-1:0] hi_s, lo_s, pe_s;
  logic          lo_ok_s;
  logic          bright_pass_s, dark_pass_s;
`ifdef FAST_SCORE_EN
  logic [SW-1:0] sum_b_q, sum_b_d, sum_d_q, sum_d_d;
  logic [SW-1:0] corner_score_q, corner_score_d;
  logic [SW-1:0] acc_b_s, acc_d_s;
  logic [EW-1:0] diff_s;
`endif

  // Stage 1: threshold masks (and score sums) at DATA_WIDTH+1 bits so c+t and c-t never wrap.
  always_comb begin
    hi_s          = {1'b0, center_pixel} + {1'b0, threshold};
    lo_s          = {1'b0, center_pixel} - {1'b0, threshold};
    lo_ok_s       = (center_pixel >= threshold);
    pe_s          = '0;
    v1_d          = circle_valid;
    bright_mask_d = bright_mask_q;
    dark_mask_d   = dark_mask_q;
`ifdef FAST_SCORE_EN
    acc_b_s = '0;
    acc_d_s = '0;
    diff_s  = '0;
    sum_b_d = sum_b_q;
    sum_d_d = sum_d_q;
`endif
    if (circle_valid) begin
      for (int i = 0; i < 16; i++) begin
        pe_s             = {1'b0, circle_pixel[i]};
        bright_mask_d[i] = (pe_s > hi_s);
        dark_mask_d[i]   = lo_ok_s && (pe_s < lo_s);
`ifdef FAST_SCORE_EN
        if (bright_mask_d[i]) begin
          diff_s  = pe_s - hi_s;
          acc_b_s = acc_b_s + {3'b000, diff_s};
        end else begin
          acc_b_s = acc_b_s;
        end
        if (dark_mask_d[i]) begin
          diff_s  = lo_s - pe_s;
          acc_d_s = acc_d_s + {3'b000, diff_s};
        end else begin
          acc_d_s = acc_d_s;
        end
`endif
      end
`ifdef FAST_SCORE_EN
      sum_b_d = acc_b_s;
      sum_d_d = acc_d_s;
`endif
    end else begin
      bright_mask_d = bright_mask_q;
      dark_mask_d   = dark_mask_q;
    end
  end

  // Stage 2: arc test, result hold between pulses, and per-frame corner count.
  always_comb begin
    bright_pass_s  = arc_pass(bright_mask_q);
    dark_pass_s    = arc_pass(dark_mask_q);
    corner_valid_d = v1_q;
    is_corner_d    = is_corner_q;
    corner_dark_d  = corner_dark_q;
    corner_count_d = corner_count_q;
`ifdef FAST_SCORE_EN
    corner_score_d = corner_score_q;
`endif
    if (v1_q) begin
      is_corner_d   = bright_pass_s | dark_pass_s;
      corner_dark_d = dark_pass_s;
`ifdef FAST_SCORE_EN
      corner_score_d = (sum_b_q > sum_d_q) ? sum_b_q : sum_d_q;
`endif
    end else begin
      is_corner_d   = is_corner_q;
      corner_dark_d = corner_dark_q;
    end
    // A corner registered on the frame_start edge counts toward the new frame.
    if (frame_start) begin
      corner_count_d = (v1_q && is_corner_d) ? 16'd1 : 16'd0;
    end else if (v1_q && is_corner_d && (corner_count_q != 16'hFFFF)) begin
      corner_count_d = corner_count_q + 16'd1;
    end else begin
      corner_count_d = corner_count_q;
    end
  end

  // Pipeline state; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q           <= 1'b0;
      bright_mask_q  <= 16'd0;
      dark_mask_q    <= 16'd0;
      corner_valid_q <= 1'b0;
      is_corner_q    <= 1'b0;
      corner_dark_q  <= 1'b0;
      corner_count_q <= 16'd0;
`ifdef FAST_SCORE_EN
      sum_b_q        <= '0;
      sum_d_q        <= '0;
      corner_score_q <= '0;
`endif
    end else begin
      v1_q           <= v1_d;
      bright_mask_q  <= bright_mask_d;
      dark_mask_q    <= dark_mask_d;
      corner_valid_q <= corner_valid_d;
      is_corner_q    <= is_corner_d;
      corner_dark_q  <= corner_dark_d;
      corner_count_q <= corner_count_d;
`ifdef FAST_SCORE_EN
      sum_b_q        <= sum_b_d;
      sum_d_q        <= sum_d_d;
      corner_score_q <= corner_score_d;
`endif
    end
  end

  assign corner_valid = corner_valid_q;
  assign is_corner    = is_corner_q;
  assign corner_dark  = corner_dark_q;
  assign corner_count = corner_count_q;
`ifdef FAST_SCORE_EN
  assign corner_score = corner_score_q;
`else
  assign corner_score = {SW{1'b0}};
`endif

endmodule

// File: tb/tb_fast_segment_test.sv
// Directed bench for fast_segment_test: hand-computed results for the segment test, count and reset.
module tb_fast_segment_test;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        circle_valid;
  logic [7:0]  center_pixel;
  logic [7:0]  circle_pixel [16];
  logic [7:0]  threshold;
  logic        frame_start;
  logic        corner_valid;
  logic        is_corner;
  logic        corner_dark;
  logic [11:0] corner_score;
  logic [15:0] corner_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fast_segment_test #(.DATA_WIDTH(8), .ARC_LEN(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .circle_valid (circle_valid),
    .center_pixel (center_pixel),
    .circle_pixel (circle_pixel),
    .threshold    (threshold),
    .frame_start  (frame_start),
    .corner_valid (corner_valid),
    .is_corner    (is_corner),
    .corner_dark  (corner_dark),
    .corner_score (corner_score),
    .corner_count (corner_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_ring(input logic [7:0] base, input int first, input int n, input logic [7:0] val);
    for (int i = 0; i < 16; i++) circle_pixel[i] = base;
    for (int k = 0; k < n; k++) circle_pixel[(first + k) % 16] = val;
  endtask

  function automatic logic [31:0] want_score(input logic [31:0] s);
`ifdef FAST_SCORE_EN
    return s;
`else
    return (s & 32'd0);
`endif
  endfunction

  // Called at a negedge with the ring already loaded; drives one candidate and checks its result.
  task automatic run_one(input string tag, input logic [7:0] c, input logic [7:0] t,
                         input logic exp_corner, input logic exp_dark,
                         input logic [31:0] exp_score, input logic [31:0] exp_count);
    center_pixel = c;
    threshold    = t;
    circle_valid = 1'b1;
    @(negedge clk);
    circle_valid = 1'b0;
    check({tag, "_lat1"}, {31'd0, corner_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, corner_valid}, 32'd1);
    check({tag, "_corner"}, {31'd0, is_corner}, {31'd0, exp_corner});
    check({tag, "_dark"}, {31'd0, corner_dark}, {31'd0, exp_dark});
    check({tag, "_score"}, {20'd0, corner_score}, want_score(exp_score));
    check({tag, "_count"}, {16'd0, corner_count}, exp_count);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, corner_valid}, 32'd0);
    check({tag, "_hold"}, {31'd0, is_corner}, {31'd0, exp_corner});
  endtask

  initial begin
    logic seen;
    rst_n        = 1'b0;
    circle_valid = 1'b0;
    center_pixel = 8'd0;
    threshold    = 8'd0;
    frame_start  = 1'b0;
    set_ring(8'd0, 0, 0, 8'd0);
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, corner_valid}, 32'd0);
    check("rst_corner", {31'd0, is_corner}, 32'd0);
    check("rst_dark", {31'd0, corner_dark}, 32'd0);
    check("rst_score", {20'd0, corner_score}, 32'd0);
    check("rst_count", {16'd0, corner_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'd0, corner_valid}, 32'd0);

    set_ring(8'd100, 0, 0, 8'd100);   run_one("flat",  8'd100, 8'd20, 1'b0, 1'b0, 32'd0,   32'd0);
    set_ring(8'd100, 12, 9, 8'd130);  run_one("wrap9", 8'd100, 8'd20, 1'b1, 1'b0, 32'd90,  32'd1);
    set_ring(8'd100, 0, 8, 8'd70);    run_one("arc8",  8'd100, 8'd20, 1'b0, 1'b0, 32'd80,  32'd1);
    set_ring(8'd255, 0, 0, 8'd255);   run_one("sat_b", 8'd250, 8'd10, 1'b0, 1'b0, 32'd0,   32'd1);
    set_ring(8'd0, 0, 0, 8'd0);       run_one("sat_d", 8'd5,   8'd10, 1'b0, 1'b0, 32'd0,   32'd1);
    set_ring(8'd120, 0, 0, 8'd120);   run_one("eq_hi", 8'd100, 8'd20, 1'b0, 1'b0, 32'd0,   32'd1);
    set_ring(8'd100, 3, 12, 8'd50);   run_one("dark12",8'd100, 8'd20, 1'b1, 1'b1, 32'd360, 32'd2);
    set_ring(8'd121, 0, 0, 8'd121);   run_one("all121",8'd100, 8'd20, 1'b1, 1'b0, 32'd16,  32'd3);
    set_ring(8'd100, 7, 9, 8'd121);   run_one("arc9",  8'd100, 8'd20, 1'b1, 1'b0, 32'd9,   32'd4);
    set_ring(8'd79, 0, 0, 8'd79);     run_one("all79", 8'd100, 8'd20, 1'b1, 1'b1, 32'd16,  32'd5);

    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("fs_clear", {16'd0, corner_count}, 32'd0);

    // Three corners back to back; frame_start lands on the edge that registers the 2nd result.
    set_ring(8'd100, 12, 9, 8'd130);
    center_pixel = 8'd100;
    threshold    = 8'd20;
    circle_valid = 1'b1;
    repeat (2) @(negedge clk);
    frame_start = 1'b1;
    check("b2b_v1", {31'd0, corner_valid}, 32'd1);
    check("b2b_c1", {16'd0, corner_count}, 32'd1);
    @(negedge clk);
    circle_valid = 1'b0;
    frame_start  = 1'b0;
    check("b2b_v2", {31'd0, corner_valid}, 32'd1);
    check("b2b_c2", {16'd0, corner_count}, 32'd1);
    @(negedge clk);
    check("b2b_v3", {31'd0, corner_valid}, 32'd1);
    check("b2b_c3", {16'd0, corner_count}, 32'd2);
    @(negedge clk);
    check("b2b_end", {31'd0, corner_valid}, 32'd0);

    // Reset with two candidates in flight.
    circle_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", {31'd0, corner_valid}, 32'd0);
    check("mrst_count", {16'd0, corner_count}, 32'd0);
    check("mrst_corner", {31'd0, is_corner}, 32'd0);
    @(negedge clk);
    circle_valid = 1'b0;
    rst_n        = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | corner_valid;
    end
    check("mrst_no_result", {31'd0, seen}, 32'd0);
    check("mrst_count_after", {16'd0, corner_count}, 32'd0);
    run_one("post_rst", 8'd100, 8'd20, 1'b1, 1'b0, 32'd90, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
